// File: rtl/timer_pkg.sv
// Constants shared by the timer_8bit blocks: TCR bit positions and the widths of
// the prescaler and of its clock-select field.
package timer_pkg;
   localparam int TCR_LOAD_BIT = 7;
   localparam int TCR_EN_BIT   = 4;
   localparam int TCR_CKS_LSB  = 0;
   localparam int CKS_W        = 2;
   localparam int DIV_W        = 4;
endpackage

// File: rtl/clk_sel_sync.sv
// Holds the clock select in effect. A new select is accepted only while cleared or
// in the prescaler wrap cycle, so a change can never cut a divided pulse short.
module clk_sel_sync
   import timer_pkg::*;
#(
   parameter int DIV_W = timer_pkg::DIV_W,
   parameter int CKS_W = timer_pkg::CKS_W
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             clr,
   input  logic [DIV_W-1:0] div_cnt,
   input  logic [CKS_W-1:0] cks_req,
   output logic [CKS_W-1:0] cks_active
);
   logic             wrap;
   logic [CKS_W-1:0] cks_active_d;
   logic [CKS_W-1:0] cks_active_q;

   // At the wrap every tap drops low on the same edge, making the switch glitch-free.
   assign wrap = &div_cnt;

   always_comb begin
      cks_active_d = cks_active_q;
      if (clr || wrap) begin
         cks_active_d = cks_req;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         cks_active_q <= '0;
      end else begin
         cks_active_q <= cks_active_d;
      end
   end

   assign cks_active = cks_active_q;
endmodule

// File: rtl/clk_prescaler.sv
// Divides pclk by 2**(cks+1) for the 8-bit timer counter: a registered 50% duty
// clk_in plus a one-pclk clk_tick in the cycle clk_in rises.
module clk_prescaler #(
   parameter int DIV_W = timer_pkg::DIV_W,
   parameter int CKS_W = timer_pkg::CKS_W
) (
   input  logic             pclk,
   input  logic             preset,
   input  logic [7:0]       TCR,
   output logic             clk_in,
   output logic             clk_tick,
   output logic [CKS_W-1:0] cks_active,
   output logic [DIV_W-1:0] div_cnt
);
   import timer_pkg::*;

   logic             clr;
   logic             tap;
   logic [CKS_W-1:0] cks_req;
   logic [CKS_W-1:0] cks_active_w;
   logic [DIV_W-1:0] div_cnt_d;
   logic [DIV_W-1:0] div_cnt_q;
   logic             clk_in_d;
   logic             clk_in_q;
   logic             clk_tick_d;
   logic             clk_tick_q;
   logic             unused_tcr;

   assign unused_tcr = ^{TCR[6:5], TCR[3:2]};

   // Load holds the phase at zero so counting resumes aligned with the load release.
   assign clr     = ~TCR[TCR_EN_BIT] | TCR[TCR_LOAD_BIT];
   assign cks_req = TCR[TCR_CKS_LSB +: CKS_W];

   clk_sel_sync #(
      .DIV_W (DIV_W),
      .CKS_W (CKS_W)
   ) u_clk_sel_sync (
      .clk        (pclk),
      .srst       (preset),
      .clr        (clr),
      .div_cnt    (div_cnt_q),
      .cks_req    (cks_req),
      .cks_active (cks_active_w)
   );

   assign tap = div_cnt_q[cks_active_w];

   always_comb begin
      div_cnt_d  = div_cnt_q + DIV_W'(1);
      clk_in_d   = tap;
      clk_tick_d = ~clk_in_q & tap;
      if (clr) begin
         div_cnt_d  = '0;
         clk_in_d   = 1'b0;
         clk_tick_d = 1'b0;
      end
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         div_cnt_q  <= '0;
         clk_in_q   <= 1'b0;
         clk_tick_q <= 1'b0;
      end else begin
         div_cnt_q  <= div_cnt_d;
         clk_in_q   <= clk_in_d;
         clk_tick_q <= clk_tick_d;
      end
   end

   assign clk_in     = clk_in_q;
   assign clk_tick   = clk_tick_q;
   assign cks_active = cks_active_w;
   assign div_cnt    = div_cnt_q;
endmodule

// File: tb/tb_clk_prescaler.sv
// Self-checking bench for clk_prescaler: vector table, directed corner sequences
// and a randomized run against a cycle-count reference model.
module tb_clk_prescaler;
   logic       pclk = 1'b0;
   logic       preset = 1'b1;
   logic [7:0] TCR = 8'h00;
   logic       clk_in;
   logic       clk_tick;
   logic [1:0] cks_active;
   logic [3:0] div_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model: count of edges since the last clear, the select in effect,
   // and the previous clk_in level for the rise detect.
   int   m_n   = 0;
   int   m_sel = 0;
   logic m_ci  = 1'b0;
   logic m_tk  = 1'b0;

   typedef struct {
      logic       p;
      logic [7:0] tcr;
      logic       ci;
      logic       tk;
      logic [1:0] cks;
      logic [3:0] div;
   } vec_t;

   vec_t tbl[12];

   clk_prescaler dut (
      .pclk       (pclk),
      .preset     (preset),
      .TCR        (TCR),
      .clk_in     (clk_in),
      .clk_tick   (clk_tick),
      .cks_active (cks_active),
      .div_cnt    (div_cnt)
   );

   always #5 pclk = ~pclk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic model_update(input logic p, input logic [7:0] t);
      logic new_ci;
      if (p) begin
         m_n = 0; m_sel = 0; m_ci = 1'b0; m_tk = 1'b0;
      end else if (!t[4] || t[7]) begin
         m_n = 0; m_sel = int'(t[1:0]); m_ci = 1'b0; m_tk = 1'b0;
      end else begin
         // clk_in is the bit of weight 2**sel of the pre-edge count
         new_ci = ((m_n / (1 << m_sel)) % 2) == 1;
         m_tk = new_ci && !m_ci;
         if (m_n == 15) m_sel = int'(t[1:0]);
         m_n = (m_n + 1) % 16;
         m_ci = new_ci;
      end
   endtask

   task automatic step(input logic p, input logic [7:0] t);
      preset = p;
      TCR = t;
      model_update(p, t);
      @(posedge pclk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   initial begin
      int ticks, first_rise, highs, highs2;
      int cur_cks;
      logic p;
      logic [7:0] t;

      tbl[0]  = '{1'b1, 8'h13, 1'b0, 1'b0, 2'd0, 4'd0};
      tbl[1]  = '{1'b1, 8'h13, 1'b0, 1'b0, 2'd0, 4'd0};
      tbl[2]  = '{1'b1, 8'h13, 1'b0, 1'b0, 2'd0, 4'd0};
      tbl[3]  = '{1'b0, 8'h10, 1'b0, 1'b0, 2'd0, 4'd1};
      tbl[4]  = '{1'b0, 8'h10, 1'b1, 1'b1, 2'd0, 4'd2};
      tbl[5]  = '{1'b0, 8'h10, 1'b0, 1'b0, 2'd0, 4'd3};
      tbl[6]  = '{1'b0, 8'h10, 1'b1, 1'b1, 2'd0, 4'd4};
      tbl[7]  = '{1'b0, 8'h03, 1'b0, 1'b0, 2'd3, 4'd0};
      tbl[8]  = '{1'b0, 8'h13, 1'b0, 1'b0, 2'd3, 4'd1};
      tbl[9]  = '{1'b0, 8'h93, 1'b0, 1'b0, 2'd3, 4'd0};
      tbl[10] = '{1'b0, 8'h83, 1'b0, 1'b0, 2'd3, 4'd0};
      tbl[11] = '{1'b1, 8'h13, 1'b0, 1'b0, 2'd0, 4'd0};

      for (int i = 0; i < 12; i++) begin
         step(tbl[i].p, tbl[i].tcr);
         $display("vec %0d: preset=%0b TCR=%02h -> clk_in=%0b tick=%0b cks=%0d div=%0d",
                  i, tbl[i].p, tbl[i].tcr, clk_in, clk_tick, cks_active, div_cnt);
         check($sformatf("vec%0d_clk_in", i), 32'(clk_in), 32'(tbl[i].ci));
         check($sformatf("vec%0d_clk_tick", i), 32'(clk_tick), 32'(tbl[i].tk));
         check($sformatf("vec%0d_cks_active", i), 32'(cks_active), 32'(tbl[i].cks));
         check($sformatf("vec%0d_div_cnt", i), 32'(div_cnt), 32'(tbl[i].div));
      end

      // cks=0 from reset: period 2, first rise at edge 2
      ticks = 0; first_rise = 0;
      for (int e = 1; e <= 20; e++) begin
         step(1'b0, 8'h10);
         if (clk_tick) ticks++;
         if (clk_in && first_rise == 0) first_rise = e;
      end
      $display("seq cks0: ticks=%0d first_rise=%0d", ticks, first_rise);
      check("cks0_ticks", 32'(ticks), 32'd10);
      check("cks0_first_rise", 32'(first_rise), 32'd2);

      // cks=3 from a cleared state: period 16, first rise at edge 9
      step(1'b0, 8'h03);
      ticks = 0; first_rise = 0; highs = 0;
      for (int e = 1; e <= 48; e++) begin
         step(1'b0, 8'h13);
         if (clk_tick) ticks++;
         if (clk_in) highs++;
         if (clk_in && first_rise == 0) first_rise = e;
      end
      $display("seq cks3: ticks=%0d first_rise=%0d highs=%0d", ticks, first_rise, highs);
      check("cks3_ticks", 32'(ticks), 32'd3);
      check("cks3_first_rise", 32'(first_rise), 32'd9);
      check("cks3_high_cycles", 32'(highs), 32'd24);

      // cks 3->0 requested at div_cnt=5 takes effect only at the wrap
      step(1'b0, 8'h03);
      for (int k = 0; k < 20 && div_cnt != 4'd5; k++) step(1'b0, 8'h13);
      check("sel_chg_reach_div5", 32'(div_cnt), 32'd5);
      highs = 0; highs2 = 0;
      for (int e = 6; e <= 20; e++) begin
         step(1'b0, 8'h10);
         if (clk_in && e <= 16) highs++;
         if (clk_in && e > 16) highs2++;
         if (e == 15) check("sel_chg_held_before_wrap", 32'(cks_active), 32'd3);
         if (e == 16) begin
            check("sel_chg_after_wrap", 32'(cks_active), 32'd0);
            check("sel_chg_wrap_div", 32'(div_cnt), 32'd0);
         end
      end
      $display("seq sel_chg: old_high=%0d new_highs=%0d", highs, highs2);
      check("sel_chg_old_high_len", 32'(highs), 32'd8);
      check("sel_chg_new_highs", 32'(highs2), 32'd2);

      // load pulse mid-period with cks=1
      step(1'b0, 8'h01);
      for (int k = 0; k < 5; k++) step(1'b0, 8'h11);
      for (int k = 0; k < 2; k++) begin
         step(1'b0, 8'h91);
         check($sformatf("load%0d_div", k), 32'(div_cnt), 32'd0);
         check($sformatf("load%0d_clk_in", k), 32'(clk_in), 32'd0);
      end
      first_rise = 0;
      for (int e = 1; e <= 8; e++) begin
         step(1'b0, 8'h11);
         if (clk_in && first_rise == 0) first_rise = e;
      end
      $display("seq load: first_rise_after_load=%0d", first_rise);
      check("load_rise_edge", 32'(first_rise), 32'd3);

      // disable while high, then reset while enabled
      step(1'b0, 8'h01);
      for (int k = 0; k < 10 && !clk_in; k++) step(1'b0, 8'h11);
      check("dis_reached_high", 32'(clk_in), 32'd1);
      step(1'b0, 8'h01);
      $display("seq disable: clk_in=%0b tick=%0b div=%0d", clk_in, clk_tick, div_cnt);
      check("dis_clk_in", 32'(clk_in), 32'd0);
      check("dis_tick", 32'(clk_tick), 32'd0);
      check("dis_div", 32'(div_cnt), 32'd0);
      for (int k = 0; k < 3; k++) step(1'b0, 8'h11);
      for (int k = 0; k < 2; k++) begin
         step(1'b1, 8'h11);
         check($sformatf("rst%0d_outputs", k),
               32'({clk_in, clk_tick, cks_active, div_cnt}), 32'd0);
      end

      // randomized run against the model
      cur_cks = 0;
      for (int i = 0; i < 1500; i++) begin
         p = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 9) == 0) cur_cks = int'($urandom_range(0, 3));
         t = 8'h00;
         t[1:0] = 2'(cur_cks);
         t[4] = ($urandom_range(0, 99) >= 6);
         t[7] = ($urandom_range(0, 24) == 0);
         t[6:5] = 2'($urandom_range(0, 3));
         t[3:2] = 2'($urandom_range(0, 3));
         step(p, t);
         if (i % 100 == 0)
            $display("rand %0d: preset=%0b TCR=%02h -> clk_in=%0b tick=%0b cks=%0d div=%0d",
                     i, p, t, clk_in, clk_tick, cks_active, div_cnt);
         check($sformatf("rand%0d", i),
               32'({clk_in, clk_tick, cks_active, div_cnt}),
               32'({m_ci, m_tk, 2'(m_sel), 4'(m_n)}));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
